// File: rtl/mem_io_bridge.sv
// mem_io_bridge: registered load/store access unit between the CPU
// execute/memory stage and the data memory plus NUM_IO memory-mapped I/O
// channels. Each accepted request produces exactly one resp_valid pulse.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_ready           request handshake (ready only in IDLE)
//   req_write, req_size,
//   req_unsigned, addr_in,
//   wdata_in                      request fields, captured on accept
//   resp_valid, resp_err, rdata   one-cycle completion with load result
//   mem_addr, mem_re, mem_we,
//   mem_be, mem_wdata, mem_rdata  data-memory side (word address, lanes)
//   io_re, io_we, io_wdata,
//   io_rdata                      one-hot I/O channel strobes and data
//
// Build option
//   MEMIO_ALIGN_CHECK_EN  defined: misaligned memory accesses respond with
//                         resp_err and issue no strobes. Undefined: the low
//                         address bits are truncated and the access proceeds.
module mem_io_bridge #(
  parameter int          DATA_W  = 32,
  parameter int          IO_W    = 16,
  parameter int          NUM_IO  = 4,
  parameter logic [31:0] IO_BASE = 32'hFFFF_FC00,
  parameter int          MEM_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [1:0]             req_size,
  input  logic                   req_unsigned,
  input  logic [31:0]            addr_in,
  input  logic [DATA_W-1:0]      wdata_in,
  output logic                   resp_valid,
  output logic                   resp_err,
  output logic [DATA_W-1:0]      rdata,
  output logic [31:0]            mem_addr,
  output logic                   mem_re,
  output logic                   mem_we,
  output logic [3:0]             mem_be,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic [NUM_IO-1:0]      io_re,
  output logic [NUM_IO-1:0]      io_we,
  output logic [IO_W-1:0]        io_wdata,
  input  logic [NUM_IO*IO_W-1:0] io_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, MEM_WAIT, RESP} state_t;

  state_t              state_q;
  logic [2:0]          cnt_q;
  logic                resp_valid_q, resp_err_q;
  logic [DATA_W-1:0]   rdata_q, res_q;
  logic [31:0]         mem_addr_q;
  logic                mem_re_q, mem_we_q;
  logic [3:0]          mem_be_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [NUM_IO-1:0]   io_re_q, io_we_q;
  logic [IO_W-1:0]     io_wdata_q;

  // captured request attributes
  logic                write_q, uns_q, io_q, err_q;
  logic [1:0]          size_q, off_q;
  logic [5:0]          ch_q;

  // decode of the request currently on the inputs
  logic                is_half_d, is_word_d, io_d, ch_bad_d, err_d;
  logic [5:0]          ch_d;
  logic [1:0]          off_d;
  logic [3:0]          be_d;
  logic [DATA_W-1:0]   wdata_d;
  logic [NUM_IO-1:0]   io_sel_d;
  logic [IO_W-1:0]     io_sel_data;

  // lane select and extension of a memory word for a load
  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] word,
                                                    input logic [1:0] off,
                                                    input logic [1:0] size,
                                                    input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (size)
      2'b00:   load_extend = uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   load_extend = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: load_extend = word;
    endcase
  endfunction

  always_comb begin
    is_word_d = req_size[1];
    is_half_d = (req_size == 2'b01);
    io_d      = (addr_in[31:10] == IO_BASE[31:10]);
    ch_d      = addr_in[9:4];
    ch_bad_d  = io_d && ({1'b0, ch_d} >= 7'(NUM_IO));
`ifdef MEMIO_ALIGN_CHECK_EN
    off_d = addr_in[1:0];
    // alignment only matters on the memory side; I/O ignores the size
    err_d = ch_bad_d | (~io_d & ((is_half_d & addr_in[0]) |
                                 (is_word_d & (addr_in[1:0] != 2'b00))));
`else
    // misaligned halves/words fall back to the naturally aligned offset
    off_d = is_word_d ? 2'b00 : (is_half_d ? {addr_in[1], 1'b0} : addr_in[1:0]);
    err_d = ch_bad_d;
`endif
    case (req_size)
      2'b00:   be_d = 4'b0001 << off_d;
      2'b01:   be_d = 4'b0011 << off_d;
      default: be_d = 4'hF;
    endcase
    case (req_size)
      2'b00:   wdata_d = {4{wdata_in[7:0]}};
      2'b01:   wdata_d = {2{wdata_in[15:0]}};
      default: wdata_d = wdata_in;
    endcase
    io_sel_d = NUM_IO'(1) << ch_d;
  end

  always_comb begin
    io_sel_data = '0;
    for (int k = 0; k < NUM_IO; k++)
      if (ch_q == 6'(k)) io_sel_data = io_rdata[k*IO_W +: IO_W];
  end

  // control FSM and all registered outputs; strobes are loaded on the
  // accept edge so they are visible for exactly the ISSUE cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      io_re_q      <= '0;
      io_we_q      <= '0;
      io_wdata_q   <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            state_q <= ISSUE;
            if (!err_d && !io_d) begin
              mem_re_q    <= ~req_write;
              mem_we_q    <= req_write;
              mem_addr_q  <= {addr_in[31:2], 2'b00};
              mem_be_q    <= be_d;
              mem_wdata_q <= wdata_d;
            end
            if (!err_d && io_d) begin
              io_re_q    <= req_write ? '0 : io_sel_d;
              io_we_q    <= req_write ? io_sel_d : '0;
              io_wdata_q <= wdata_in[IO_W-1:0];
            end
          end
        end
        ISSUE: begin
          mem_re_q <= 1'b0;
          mem_we_q <= 1'b0;
          mem_be_q <= '0;
          io_re_q  <= '0;
          io_we_q  <= '0;
          if (!err_q && !io_q && !write_q) begin
            state_q <= MEM_WAIT;
            cnt_q   <= 3'(MEM_LAT - 1);
          end else begin
            state_q <= RESP;
          end
        end
        MEM_WAIT: begin
          if (cnt_q == 3'd0) state_q <= RESP;
          else               cnt_q   <= cnt_q - 3'd1;
        end
        RESP: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b1;
          resp_err_q   <= err_q;
          rdata_q      <= res_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // request capture and load result; data only, no reset needed
  always_ff @(posedge clk) begin
    if (state_q == IDLE && req_valid) begin
      write_q <= req_write;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      off_q   <= off_d;
      io_q    <= io_d;
      ch_q    <= ch_d;
      err_q   <= err_d;
    end
    // I/O reads sample the channel during ISSUE; stores and errors return 0
    if (state_q == ISSUE)
      res_q <= (err_q || write_q || !io_q) ? '0 : DATA_W'(io_sel_data);
    if (state_q == MEM_WAIT && cnt_q == 3'd0)
      res_q <= load_extend(mem_rdata, off_q, size_q, uns_q);
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign rdata      = rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_re     = mem_re_q;
  assign mem_we     = mem_we_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;
  assign io_re      = io_re_q;
  assign io_we      = io_we_q;
  assign io_wdata   = io_wdata_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Testbench for mem_io_bridge: requests are driven one after another, the
// expected response of each is queued on acceptance and compared when
// resp_valid appears. Memory answers reads after exactly MEM_LAT cycles.
module tb_mem_io_bridge;
  localparam int          LAT = 3;
  localparam int          NIO = 4;
  localparam int          IOW = 16;
  localparam logic [31:0] IOB = 32'hFFFF_FC00;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]        req_size;
  logic [31:0]       addr_in, wdata_in;
  logic              resp_valid, resp_err;
  logic [31:0]       rdata, mem_addr, mem_wdata, mem_rdata;
  logic              mem_re, mem_we;
  logic [3:0]        mem_be;
  logic [NIO-1:0]    io_re, io_we;
  logic [IOW-1:0]    io_wdata;
  logic [NIO*IOW-1:0] io_rdata;

  always #5 clk = ~clk;

  mem_io_bridge #(.DATA_W(32), .IO_W(IOW), .NUM_IO(NIO), .IO_BASE(IOB), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .addr_in(addr_in), .wdata_in(wdata_in), .resp_valid(resp_valid),
    .resp_err(resp_err), .rdata(rdata), .mem_addr(mem_addr), .mem_re(mem_re),
    .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .io_re(io_re), .io_we(io_we), .io_wdata(io_wdata), .io_rdata(io_rdata)
  );

  // channels 3..0
  assign io_rdata = {16'h8F00, 16'hA5A5, 16'h2222, 16'h1111};

  typedef struct {
    int          id;
    logic        err;
    logic [31:0] rd;
    int          acc;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0, n_pass = 0, cyc = 0, n_resp = 0, last_acc = 0, next_id = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // data memory with exact read latency; garbage outside the valid window
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'h8844_22F1;
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  logic [31:0] mword;
  int          mcnt = 0;
  always @(posedge clk) begin
    mem_rdata <= 32'hDEAD_BEEF;
    if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) mem_rdata <= mword;
    end
    if (mem_re) begin
      mword <= mem_word(mem_addr);
      if (LAT == 1) mem_rdata <= mem_word(mem_addr);
      else          mcnt      <= LAT - 1;
    end
  end

  // response scoreboard and strobe-width monitor
  logic prev_stb = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    logic cur;
    cur = mem_re | mem_we | (|io_re) | (|io_we);
    if (rst) begin
      prev_stb = 1'b0;
    end else begin
      if (resp_valid) begin
        n_resp++;
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", resp_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("r%0d_err", e.id), resp_err, e.err);
          chk($sformatf("r%0d_rdata", e.id), rdata, e.rd);
          chk($sformatf("r%0d_latency", e.id), cyc - e.acc, e.lat);
        end
      end else begin
        chk("err_without_valid", resp_err, 0);
      end
      if (prev_stb) chk("strobe_one_cycle", cur, 0);
      prev_stb = cur;
    end
  end

  function automatic logic [13:0] stb(input logic mre, input logic mwe, input logic [3:0] be,
                                      input logic [3:0] ior, input logic [3:0] iow);
    return {mre, mwe, be, ior, iow};
  endfunction

  // called at a negedge; returns at the negedge of the ISSUE cycle
  task automatic issue(input string tag, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd, input logic [13:0] exp_stb,
                       input logic [31:0] exp_maddr, input logic [31:0] exp_wd,
                       input logic eerr, input logic [31:0] erd, input int elat);
    int   wc;
    exp_t e;
    wc = 0;
    req_write = w; req_size = sz; req_unsigned = u; addr_in = a; wdata_in = wd;
    req_valid = 1'b1;
    while (!req_ready && wc < 50) begin
      @(negedge clk);
      wc++;
    end
    if (!req_ready) begin
      chk({tag, "_accept_timeout"}, 0, 1);
      req_valid = 1'b0;
      return;
    end
    e.id = next_id; e.err = eerr; e.rd = erd; e.acc = cyc + 1; e.lat = elat;
    next_id++;
    last_acc = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, "_strobes"}, {mem_re, mem_we, mem_be, io_re, io_we}, exp_stb);
    if (mem_re | mem_we) chk({tag, "_mem_addr"}, mem_addr, exp_maddr);
    if (mem_we)          chk({tag, "_mem_wdata"}, mem_wdata, exp_wd);
    if (|io_we)          chk({tag, "_io_wdata"}, io_wdata, exp_wd[15:0]);
  endtask

  task automatic drain();
    int wc;
    wc = 0;
    while (exp_q.size() != 0 && wc < 40) begin
      @(negedge clk);
      wc++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  int a0, a1, a2, r0;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; addr_in = '0; wdata_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_resp", {resp_valid, resp_err, rdata}, 0);
    chk("rst_mem", {mem_re, mem_we, mem_be, mem_addr}, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_io", {io_re, io_we, io_wdata}, 0);
    rst = 1'b0;
    @(negedge clk);

    // memory loads from word 0x8844_22F1 at 0x100
    issue("ldb_s_100", 0, 2'b00, 0, 32'h100, 0, stb(1,0,4'b0001,0,0), 32'h100, 0, 0, 32'hFFFF_FFF1, LAT+2);
    issue("ldb_u_103", 0, 2'b00, 1, 32'h103, 0, stb(1,0,4'b1000,0,0), 32'h100, 0, 0, 32'h0000_0088, LAT+2);
    issue("ldb_s_101", 0, 2'b00, 0, 32'h101, 0, stb(1,0,4'b0010,0,0), 32'h100, 0, 0, 32'h0000_0022, LAT+2);
    issue("ldh_s_102", 0, 2'b01, 0, 32'h102, 0, stb(1,0,4'b1100,0,0), 32'h100, 0, 0, 32'hFFFF_8844, LAT+2);
    issue("ldh_u_100", 0, 2'b01, 1, 32'h100, 0, stb(1,0,4'b0011,0,0), 32'h100, 0, 0, 32'h0000_22F1, LAT+2);
    issue("ldh_u_206", 0, 2'b01, 1, 32'h206, 0, stb(1,0,4'b1100,0,0), 32'h204, 0, 0, 32'h0000_C1A1, LAT+2);
    issue("ld11_100",  0, 2'b11, 0, 32'h100, 0, stb(1,0,4'hF,0,0),    32'h100, 0, 0, 32'h8844_22F1, LAT+2);
    drain();
    repeat (3) @(negedge clk);
    chk("rdata_hold", rdata, 32'h8844_22F1);

    // stores
    issue("sth_202", 1, 2'b01, 0, 32'h202, 32'h0000_BEEF, stb(0,1,4'b1100,0,0), 32'h200, 32'hBEEF_BEEF, 0, 0, 2);
    issue("stb_301", 1, 2'b00, 0, 32'h301, 32'h1234_56A7, stb(0,1,4'b0010,0,0), 32'h300, 32'hA7A7_A7A7, 0, 0, 2);
    issue("stw_304", 1, 2'b10, 0, 32'h304, 32'hCAFE_F00D, stb(0,1,4'hF,0,0),    32'h304, 32'hCAFE_F00D, 0, 0, 2);

    // I/O accesses and errors
    issue("io_rd_ch2", 0, 2'b10, 0, IOB + 32'h20, 0, stb(0,0,0,4'b0100,0), 0, 0, 0, 32'h0000_A5A5, 2);
    issue("io_rd_ch3", 0, 2'b00, 0, IOB + 32'h30, 0, stb(0,0,0,4'b1000,0), 0, 0, 0, 32'h0000_8F00, 2);
    issue("io_wr_ch1", 1, 2'b10, 0, IOB + 32'h10, 32'h1234_5678, stb(0,0,0,0,4'b0010), 0, 32'h0000_5678, 0, 0, 2);
    issue("io_wr_ch4", 1, 2'b10, 0, IOB + 32'h40, 32'h1234_5678, stb(0,0,0,0,0), 0, 0, 1, 0, 2);
    issue("io_rd_ch5", 0, 2'b10, 0, IOB + 32'h50, 0, stb(0,0,0,0,0), 0, 0, 1, 0, 2);

    // misaligned memory loads
`ifdef MEMIO_ALIGN_CHECK_EN
    issue("ldw_mis_102", 0, 2'b10, 0, 32'h102, 0, stb(0,0,0,0,0), 0, 0, 1, 0, 2);
    issue("ldh_mis_103", 0, 2'b01, 0, 32'h103, 0, stb(0,0,0,0,0), 0, 0, 1, 0, 2);
`else
    issue("ldw_mis_102", 0, 2'b10, 0, 32'h102, 0, stb(1,0,4'hF,0,0),    32'h100, 0, 0, 32'h8844_22F1, LAT+2);
    issue("ldh_mis_103", 0, 2'b01, 0, 32'h103, 0, stb(1,0,4'b1100,0,0), 32'h100, 0, 0, 32'hFFFF_8844, LAT+2);
`endif
    drain();

    // back-to-back stores with req_valid held
    r0 = n_resp;
    issue("b2b0", 1, 2'b10, 0, 32'h400, 32'h1111_0000, stb(0,1,4'hF,0,0), 32'h400, 32'h1111_0000, 0, 0, 2);
    a0 = last_acc;
    issue("b2b1", 1, 2'b10, 0, 32'h404, 32'h2222_0000, stb(0,1,4'hF,0,0), 32'h404, 32'h2222_0000, 0, 0, 2);
    a1 = last_acc;
    issue("b2b2", 1, 2'b10, 0, 32'h408, 32'h3333_0000, stb(0,1,4'hF,0,0), 32'h408, 32'h3333_0000, 0, 0, 2);
    a2 = last_acc;
    drain();
    chk("b2b_gap01", a1 - a0, 3);
    chk("b2b_gap12", a2 - a1, 3);
    chk("b2b_resps", n_resp - r0, 3);

    // reset during ISSUE of a store: strobe must drop at once
    issue("abort_st", 1, 2'b10, 0, 32'h500, 32'h5555_5555, stb(0,1,4'hF,0,0), 32'h500, 32'h5555_5555, 0, 0, 2);
    rst = 1'b1;
    #1;
    chk("abort1_strobes", {mem_re, mem_we, mem_be, io_re, io_we}, 0);
    chk("abort1_ready", req_ready, 1);
    exp_q.delete();
    r0 = n_resp;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort1_no_resp", n_resp, r0);

    // reset during MEM_WAIT of a load
    issue("abort_ld", 0, 2'b10, 0, 32'h100, 0, stb(1,0,4'hF,0,0), 32'h100, 0, 0, 32'h8844_22F1, LAT+2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort2_ready", req_ready, 1);
    chk("abort2_strobes", {mem_re, mem_we, mem_be, io_re, io_we}, 0);
    chk("abort2_outputs", {resp_valid, resp_err, rdata}, 0);
    exp_q.delete();
    r0 = n_resp;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort2_no_resp", n_resp, r0);

    // bridge works again after the abort
    issue("post_abort", 0, 2'b00, 1, 32'h100, 0, stb(1,0,4'b0001,0,0), 32'h100, 0, 0, 32'h0000_00F1, LAT+2);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_io_bridge.md
# mem_io_bridge

Parametrised load/store bridge between the CPU execute/memory stage and the data memory plus up to `NUM_IO` memory-mapped I/O channels. It decodes each request as memory or I/O and drives byte-lane strobes for memory. Memory reads wait for a configurable read latency, and every request returns exactly one response pulse with aligned, sign- or zero-extended read data. It replaces the flat memRead/ioRead data multiplexer with a registered, handshaked access unit.

## Interface
- `DATA_W`, 32: CPU data width; fixed at 32 for byte-lane logic.
- `IO_W`, 16: width of each I/O channel's data.
- `NUM_IO`, 4: number of I/O channels, 1..64.
- `IO_BASE`, 32'hFFFF_FC00: base of the 1 KiB I/O window; must be 1 KiB aligned.
- `MEM_LAT`, 1: data-memory read latency in cycles, 1..7.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  bridge can accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- `req_unsigned`  in  1  zero-extend loads when 1; sign-extend when 0.
- `addr_in`  in  32  byte address from the ALU.
- `wdata_in`  in  32  store data from the register file.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_err`  out  1  error flag, valid with `resp_valid`.
- `rdata`  out  32  load result, valid with `resp_valid`.
- `mem_addr`  out  32  word-aligned memory address.
- `mem_re`, `mem_we`  out  1  memory read and write strobes.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-replicated write data.
- `mem_rdata`  in  32  memory read data.
- `io_re`, `io_we`  out  NUM_IO  one-hot channel strobes.
- `io_wdata`  out  IO_W  I/O write data.
- `io_rdata`  in  NUM_IO*IO_W  packed channel read data; channel k occupies bits [k*IO_W +: IO_W].

## Operation
- **States:** IDLE, ISSUE, MEM_WAIT, RESP.
- **`req_ready`:** equals (state == IDLE).
- **IDLE:** when `req_valid` is 1, register `addr_in`, `req_write`, `req_size`, `req_unsigned` and `wdata_in`, then go to ISSUE.
- **Decode:**
  - I/O when `addr[31:10] == IO_BASE[31:10]`.
  - Channel index = `addr[9:4]`.
  - An index ≥ `NUM_IO` is an error.
- **Alignment:** a half access with `addr[0]=1` is misaligned; a word access with `addr[1:0]≠0` is misaligned.
- **ISSUE, error request:** no strobes; go to RESP with `resp_err=1` and `rdata=0`.
- **ISSUE, memory:**
  - Assert `mem_re` or `mem_we` for exactly this cycle.
  - `mem_addr = {addr[31:2],2'b00}`.
  - `mem_be`: byte → `4'b0001<<addr[1:0]`; half → `4'b0011<<addr[1:0]`; word → `4'hF`.
  - `mem_wdata`: byte → the byte replicated 4 times; half → the half replicated 2 times; word → unchanged.
  - Write → go to RESP. Read → go to MEM_WAIT.
- **MEM_WAIT:**
  - Count `MEM_LAT` cycles after the `mem_re` cycle.
  - Capture `mem_rdata` on the last counted edge.
  - Select the lane by `addr[1:0]` and extend to 32 bits per `req_unsigned`.
  - Go to RESP.
- **ISSUE, I/O:**
  - Assert `io_re[ch]` or `io_we[ch]` for exactly this cycle.
  - `io_wdata = wdata[IO_W-1:0]`.
  - Reads sample `io_rdata` for channel `ch` in this cycle; the value is always zero-extended and `req_size` is ignored.
  - Go to RESP.
- **RESP:** `resp_valid=1` for one cycle; return to IDLE.

## Timing
- **Reset values:** state IDLE; `req_ready=1`; all other outputs 0.
- **Latency from the accept edge to `resp_valid`:**
  - store or error: 2 cycles;
  - I/O read: 2 cycles;
  - memory read: 2 + `MEM_LAT` cycles.
- All outputs are registered except `req_ready`.
- `rdata` holds its value until the next response; `resp_err` is 0 whenever `resp_valid` is 0.
- A request presented while `req_ready=0` is ignored; the requester holds it until accepted.
- Back-to-back: a new request is accepted on the cycle after RESP.
- `rst` asserted mid-transaction aborts it: strobes drop immediately, and no response is ever issued for the aborted request.

## Configuration
- **`MEMIO_ALIGN_CHECK_EN` defined:** misaligned accesses raise `resp_err` as described and issue no strobes.
- **`MEMIO_ALIGN_CHECK_EN` undefined:**
  - Misaligned addresses are silently truncated: half uses `addr[0]=0`; word uses `addr[1:0]=0`.
  - The access proceeds as aligned.
  - `resp_err` is raised only for an out-of-range I/O channel.

## Test plan
- **Sign-extended byte load:** memory word `0x8844_22F1` at 0x100; load byte, signed, `addr=0x100`, `MEM_LAT=3` → `mem_re` 1 cycle after accept; `resp_valid` 5 cycles after accept; `rdata=0xFFFF_FFF1`.
- **Halfword store:** store half `0x0000_BEEF` to 0x202 → `mem_be=4'b1100`, `mem_wdata=0xBEEF_BEEF`, `mem_we` for 1 cycle, `resp_err=0`.
- **I/O read:** channel 2 `io_rdata` = `0xA5A5`; word load from `IO_BASE+0x20` → `io_re=4'b0100` for 1 cycle, `rdata=0x0000_A5A5`.
- **I/O errors:** store to `IO_BASE+0x40` with `NUM_IO=4` → no strobes, `resp_err=1`, `rdata=0`. Word load from 0x102 → error with the macro defined; without it, `mem_addr=0x100` and no error.
- **Reset abort:** accept a load with `MEM_LAT=3`; assert `rst` during MEM_WAIT → outputs 0, `req_ready=1`, no `resp_valid`.
- **Back-to-back:** hold `req_valid` for 3 consecutive stores → accepts are spaced exactly 3 cycles apart, with 3 `resp_valid` pulses.
